// File: rtl/chroma_pkg.sv
// Shared constants and types for chroma 8x8 prediction/reconstruction.
// Mode codes, block geometry and the reconstruction FSM state type.
package chroma_pkg;

  localparam logic [1:0] MODE_V   = 2'd0;
  localparam logic [1:0] MODE_H   = 2'd1;
  localparam logic [1:0] MODE_DC  = 2'd2;
  localparam logic [1:0] MODE_BAD = 2'd3;

  localparam int BLK_SAMPLES = 64;
  localparam int ROW_SAMPLES = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

endpackage

// File: rtl/clip_add8.sv
// One column lane: 8-bit unsigned pred plus signed residual, clipped 0..255.
// Ports: pred (u8), res (signed RES_W), sum (u8 saturated).
module clip_add8 #(
  parameter int RES_W = 9
) (
  input  logic [7:0]       pred,
  input  logic [RES_W-1:0] res,
  output logic [7:0]       sum
);

  localparam int SW = RES_W + 2;
  localparam logic signed [SW-1:0] MAXV = SW'(255);

  logic signed [SW-1:0] s;

  always_comb begin
    s = $signed({{(SW-8){1'b0}}, pred})
      + $signed({{2{res[RES_W-1]}}, res});
    if (s[SW-1])
      sum = 8'd0;
    else if (s > MAXV)
      sum = 8'd255;
    else
      sum = s[7:0];
  end

endmodule

// File: rtl/recon_chroma8x8.sv
// Chroma 8x8 reconstruction: recon = clip(pred + residual), row per handshake.
// Ports: start/mode/vpred/hpred/dcpred in, res_* row in, recon_* block out, busy, err_mode.
module recon_chroma8x8
  import chroma_pkg::*;
#(
  parameter int RES_W = 9,
  parameter int ROWS  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [1:0]                   mode,
  input  logic [63:0][7:0]             vpred,
  input  logic [63:0][7:0]             hpred,
  input  logic [63:0][7:0]             dcpred,
  input  logic                         res_valid,
  output logic                         res_ready,
  input  logic [7:0][RES_W-1:0]        res_row,
  output logic [63:0][7:0]             recon,
  output logic                         recon_valid,
  input  logic                         recon_ready,
  output logic                         busy,
  output logic                         err_mode
);

  state_t state, nxt;

  logic [2:0]       row;
  logic [63:0][7:0] pred_q;
  logic [63:0][7:0] pred_sel;
  logic [7:0][7:0]  lane;
  logic             hs;
  logic             take;
  logic             start_ok;
  logic             load;
  logic             err_d;

  assign res_ready   = (state == LOAD);
  assign recon_valid = (state == DONE);
  assign busy        = (state != IDLE);

  assign hs       = res_valid && res_ready;
  assign start_ok = start && (mode != MODE_BAD);
  // Block start is honoured in IDLE, or in DONE when the block is taken.
  assign take     = (state == IDLE)
                 || (state == DONE && recon_ready);
  assign load     = take && start_ok;
  assign err_d    = take && start && (mode == MODE_BAD);

  always_comb begin
    pred_sel = vpred;
    unique case (1'b1)
      (mode == MODE_H):  pred_sel = hpred;
      (mode == MODE_DC): pred_sel = dcpred;
      default:           pred_sel = vpred;
    endcase
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (load) nxt = LOAD;
      LOAD: if (hs && row == 3'(ROWS-1)) nxt = DONE;
      DONE: if (recon_ready) nxt = load ? LOAD : IDLE;
      default: nxt = IDLE;
    endcase
  end

  genvar g;
  generate
    for (g = 0; g < ROW_SAMPLES; g++) begin : g_lane
      clip_add8 #(.RES_W(RES_W)) u_clip (
        .pred (pred_q[{row, 3'(g)}]),
        .res  (res_row[g]),
        .sum  (lane[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      row      <= '0;
      pred_q   <= '0;
      recon    <= '0;
      err_mode <= 1'b0;
    end else begin
      state    <= nxt;
      err_mode <= err_d;
      if (load) begin
        pred_q <= pred_sel;
        row    <= '0;
      end else if (hs) begin
        row <= row + 3'd1;
        for (int c = 0; c < ROW_SAMPLES; c++)
          recon[{row, c[2:0]}] <= lane[c];
      end
    end
  end

endmodule
